popcount_seq: RTL and testbench
===============================

# popcount_seq

Sequential, parametrised population counter that succeeds the fixed 8-bit combinational ones counter. It accepts a WIDTH-bit word over a valid/ready handshake and counts its set bits CHUNK bits per clock. It returns the count over a second valid/ready handshake, so wide words can be counted without a wide adder tree. It sits between a producer of data words (for example a match-vector or error-mask register) and a consumer of bit counts, and is usable at any word width that is a multiple of CHUNK.

## Interface
- WIDTH, 32: input word width; must be a multiple of CHUNK and at least CHUNK.
- CHUNK, 8: bits counted per clock; the per-cycle adder is CW bits wide.
- ACC_W, 16: accumulator width, used only when POPCOUNT_ACCUM_EN is defined.
- Derived values, not parameters:
  - CW = $clog2(WIDTH+1).
  - N = WIDTH/CHUNK.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  producer has a word.
- in_ready  out  1  block can accept a word.
- in_data  in  WIDTH  word to count.
- out_valid  out  1  count is available.
- out_ready  in  1  consumer takes the count.
- out_count  out  CW  number of ones in the accepted word.
- acc_clr  in  1  clears the accumulator (POPCOUNT_ACCUM_EN only).
- acc_total  out  ACC_W  running saturating total (POPCOUNT_ACCUM_EN only).

## Operation
- There are three states: IDLE, COUNT and DONE.
- Reset values: state=IDLE, in_ready=0 while rst is high, out_valid=0, out_count=0, internal chunk index=0, acc_total=0.
- IDLE:
  - in_ready=1.
  - on in_valid&&in_ready, latch in_data into a shift register, clear the partial sum and index, and go to COUNT.
- COUNT:
  - in_ready=0.
  - each cycle add the popcount of the low CHUNK bits to the partial sum, shift the register right by CHUNK, and increment the index.
  - after the N-th add, load out_count with the final sum, set out_valid=1, and go to DONE.
- DONE:
  - out_valid=1; out_count is held stable until the handshake completes.
  - in_ready=out_ready, so the block can chain back to back.
  - on out_ready: out_valid falls next cycle.
    - if in_valid is also high in the same cycle, the new word is latched and the state goes directly to COUNT.
    - otherwise the state goes to IDLE.
- Arithmetic:
  - the partial sum is CW bits and cannot overflow, because its maximum is WIDTH.
  - chunk popcount is a pure combinational sum of CHUNK bits.
- in_data is sampled only on the accepting edge; later changes to it are ignored.
- in_valid is ignored in COUNT.
- out_ready is ignored outside DONE.

## Timing
- Latency: a word accepted at rising edge k produces out_valid=1 after edge k+N.
- Throughput:
  - one word per N+1 cycles with out_ready held high (DONE overlaps with the next accept).
  - for N=1, the best case is one word every 2 cycles.
- Backpressure: DONE holds indefinitely with out_count and out_valid stable until out_ready.
- Reset mid-operation:
  - assertion of rst at any time immediately forces all reset values, asynchronously.
  - the in-flight word is discarded and no partial result is ever presented.
- Deassertion of rst is synchronous to the next clk edge. The first accept is possible on the first edge after release.

## Configuration
- POPCOUNT_ACCUM_EN defined:
  - acc_clr and acc_total exist.
  - on every output handshake (out_valid&&out_ready), acc_total <= min(acc_total + out_count, 2^ACC_W-1); the accumulator saturates and never wraps.
  - acc_clr alone sets acc_total=0 on the next edge.
  - acc_clr together with a handshake sets acc_total=out_count, so the clear applies before the add.
  - acc_total is 0 after reset.
- POPCOUNT_ACCUM_EN undefined:
  - acc_clr and acc_total are absent from the port list.
  - no accumulator logic is generated.
  - the counting behaviour is identical to the defined case.

## Test plan
- WIDTH=32, CHUNK=8, out_ready=1, in_data=0xFFFFFFFF accepted at edge k:
  - out_valid rises after edge k+4 with out_count=32.
  - in_ready=1 during DONE.
- Counting patterns:
  - 0x00000000 gives 0.
  - 0x80000001 gives 2.
  - 0x0F0F00F0 gives 12.
  - 0xAAAAAAAA gives 16.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid rises.
  - out_valid and out_count stay constant.
  - in_ready=0.
  - toggling in_data has no effect.
- Back to back: in_valid held high with 0x00000001 then 0x00000003, out_ready=1.
  - second word accepted on the same edge as the first result's handshake.
  - counts 1 then 2.
  - results are 5 cycles apart.
- Reset during COUNT: rst pulses high after two COUNT cycles of 0xFFFFFFFF.
  - out_valid=0, out_count=0 and in_ready=0 while rst is high.
  - the block returns to IDLE with in_ready=1 after release.
  - no result is ever emitted for that word.
- POPCOUNT_ACCUM_EN, ACC_W=6:
  - three handshakes of 0xFFFFFFFF give acc_total 32, then 63, then 63 (saturated).
  - acc_clr together with a count-5 handshake gives acc_total=5.

Source files
------------

// File: rtl/popcount_seq.sv
// Sequential population counter: accepts a WIDTH-bit word and counts its ones CHUNK bits per clock.
// Optional saturating running total of all delivered counts, enabled by defining POPCOUNT_ACCUM_EN.
module popcount_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
`ifdef POPCOUNT_ACCUM_EN
  ,
  parameter int ACC_W = 16
`endif
) (
  input  logic                     clk,
  input  logic                     rst,
`ifdef POPCOUNT_ACCUM_EN
  input  logic                     acc_clr,
  output logic [ACC_W-1:0]         acc_total,
`endif
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(WIDTH+1)-1:0] out_count
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int N  = WIDTH / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_COUNT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  function automatic logic [CW-1:0] chunk_pc(input logic [CHUNK-1:0] c);
    logic [CW-1:0] s;
    s = '0;
    for (int i = 0; i < CHUNK; i++) s = s + CW'(c[i]);
    return s;
  endfunction

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    sum_q, sum_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             out_valid_q, out_valid_d;
  logic [CW-1:0]    out_count_q, out_count_d;
  logic [CW-1:0]    chunk_sum;
  logic             accept;

  // Held low during reset so nothing is accepted while the block is being cleared.
  assign in_ready  = !rst && ((state_q == S_IDLE) || ((state_q == S_DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_count = out_count_q;

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    sum_d       = sum_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_count_d = out_count_q;
    chunk_sum   = sum_q + chunk_pc(shift_q[CHUNK-1:0]);
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          shift_d = in_data;
          sum_d   = '0;
          idx_d   = '0;
          state_d = S_COUNT;
        end
      end
      S_COUNT: begin
        sum_d   = chunk_sum;
        shift_d = shift_q >> CHUNK;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST) begin
          out_count_d = chunk_sum;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (accept) begin
            shift_d = in_data;
            sum_d   = '0;
            idx_d   = '0;
            state_d = S_COUNT;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_count_q <= out_count_d;
    end
  end

  // Working data is always reloaded on accept, so it needs no reset.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    sum_q   <= sum_d;
  end

`ifdef POPCOUNT_ACCUM_EN
  localparam int SW = ((ACC_W > CW) ? ACC_W : CW) + 1;
  localparam logic [SW-1:0] ACC_MAX = SW'({ACC_W{1'b1}});

  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a, input logic [CW-1:0] b);
    logic [SW-1:0] s;
    s = SW'(a) + SW'(b);
    return (s > ACC_MAX) ? {ACC_W{1'b1}} : s[ACC_W-1:0];
  endfunction

  logic [ACC_W-1:0] acc_q, acc_d, acc_base;

  // Clear takes effect before the add when both happen on the same edge.
  always_comb begin
    acc_base = acc_clr ? '0 : acc_q;
    acc_d    = acc_base;
    if (out_valid_q && out_ready) acc_d = sat_add(acc_base, out_count_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  assign acc_total = acc_q;
`endif

endmodule

// File: tb/tb_popcount_seq.sv
// Directed bench for popcount_seq (WIDTH=32, CHUNK=8) with a queue of expected counts.
module tb_popcount_seq;
  localparam int WIDTH = 32;
  localparam int CHUNK = 8;
  localparam int CW    = $clog2(WIDTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    out_count;
`ifdef POPCOUNT_ACCUM_EN
  logic             acc_clr;
  logic [5:0]       acc_total;
`endif

  int errors = 0;
  int checks = 0;
  logic [CW-1:0] exp_q[$];

  always #5 clk = ~clk;

`ifdef POPCOUNT_ACCUM_EN
  popcount_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK), .ACC_W(6)) dut (
    .clk(clk), .rst(rst), .acc_clr(acc_clr), .acc_total(acc_total),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count)
  );
`else
  popcount_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count)
  );
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input string tag);
    logic [CW-1:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=%0h expected=<empty scoreboard>", tag, out_count);
    end else begin
      e = exp_q.pop_front();
      chk(tag, {26'd0, out_count}, {26'd0, e});
    end
  endtask

  // Counts edges until out_valid, bounded; returns the count.
  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
  endtask

  // One word through an idle block with out_ready high; handshake happens on the last step.
  task automatic run_word(input logic [WIDTH-1:0] d, input logic clr, input string tag);
    int n;
    exp_q.push_back(CW'($countones(d)));
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
    in_data  = $urandom;
    wait_valid(n);
    chk({tag, "_latency"}, n, 4);
    chk({tag, "_ready_in_done"}, {31'd0, in_ready}, 1);
    pop_check({tag, "_count"});
`ifdef POPCOUNT_ACCUM_EN
    acc_clr = clr;
`else
    if (clr) in_data = '0;
`endif
    step();
`ifdef POPCOUNT_ACCUM_EN
    acc_clr = 1'b0;
`endif
    chk({tag, "_valid_drop"}, {31'd0, out_valid}, 0);
  endtask

  initial begin
    int n;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
`ifdef POPCOUNT_ACCUM_EN
    acc_clr   = 1'b0;
`endif
    step();
    step();
    chk("rst_in_ready", {31'd0, in_ready}, 0);
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_out_count", {26'd0, out_count}, 0);
`ifdef POPCOUNT_ACCUM_EN
    chk("rst_acc_total", {26'd0, acc_total}, 0);
`endif
    rst = 1'b0;
    #1;
    chk("idle_in_ready", {31'd0, in_ready}, 1);

    // Directed counting patterns, then a few random words.
    run_word(32'hFFFF_FFFF, 1'b0, "ones");
    run_word(32'h0000_0000, 1'b0, "zero");
    run_word(32'h8000_0001, 1'b0, "ends");
    run_word(32'h0F0F_00F0, 1'b0, "nib");
    run_word(32'hAAAA_AAAA, 1'b0, "alt");
    for (int i = 0; i < 4; i++) run_word($urandom, 1'b0, "rand");

    // Backpressure: result must hold and nothing new may be accepted.
    out_ready = 1'b0;
    exp_q.push_back(CW'(16));
    in_valid = 1'b1;
    in_data  = 32'h5555_5555;
    step();
    in_data = 32'hFFFF_FFFF;
    wait_valid(n);
    chk("bp_latency", n, 4);
    for (int i = 0; i < 10; i++) begin
      in_data = $urandom;
      chk("bp_out_valid", {31'd0, out_valid}, 1);
      chk("bp_out_count", {26'd0, out_count}, 16);
      chk("bp_in_ready", {31'd0, in_ready}, 0);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    pop_check("bp_count");
    step();
    chk("bp_valid_drop", {31'd0, out_valid}, 0);
    chk("bp_idle_ready", {31'd0, in_ready}, 1);

    // Back to back: second word accepted on the first result's handshake edge.
    exp_q.push_back(CW'(1));
    exp_q.push_back(CW'(2));
    in_valid = 1'b1;
    in_data  = 32'h0000_0001;
    step();
    in_data = 32'h0000_0003;
    wait_valid(n);
    chk("b2b_latency", n, 4);
    chk("b2b_ready_in_done", {31'd0, in_ready}, 1);
    pop_check("b2b_first");
    step();
    in_valid = 1'b0;
    in_data  = 32'hFFFF_FFFF;
    chk("b2b_valid_drop", {31'd0, out_valid}, 0);
    chk("b2b_busy", {31'd0, in_ready}, 0);
    wait_valid(n);
    chk("b2b_gap", n + 1, 5);
    pop_check("b2b_second");
    step();

    // Reset in COUNT: no result for the in-flight word.
    in_valid = 1'b1;
    in_data  = 32'hFFFF_FFFF;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", {31'd0, out_valid}, 0);
    chk("mid_rst_out_count", {26'd0, out_count}, 0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 0);
    step();
    chk("mid_rst_hold_ready", {31'd0, in_ready}, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", {31'd0, in_ready}, 1);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("post_rst_no_result", {31'd0, out_valid}, 0);
    end
    run_word(32'h0000_00F0, 1'b0, "post_rst");

`ifdef POPCOUNT_ACCUM_EN
    acc_clr = 1'b1;
    step();
    acc_clr = 1'b0;
    chk("acc_clr_alone", {26'd0, acc_total}, 0);
    run_word(32'hFFFF_FFFF, 1'b0, "acc1");
    chk("acc_total_1", {26'd0, acc_total}, 32);
    run_word(32'hFFFF_FFFF, 1'b0, "acc2");
    chk("acc_total_2", {26'd0, acc_total}, 63);
    run_word(32'hFFFF_FFFF, 1'b0, "acc3");
    chk("acc_total_3", {26'd0, acc_total}, 63);
    run_word(32'h0000_001F, 1'b1, "acc_clr_hs");
    chk("acc_total_clr_hs", {26'd0, acc_total}, 5);
`endif

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
